// File: rtl/fft_input_packer.sv
// Serial-to-parallel input stage of the 256-point FFT: packs eight accepted
// samples into one 8-lane word and steers whole frames into alternating banks.
module fft_input_packer #(
  parameter int DATA_WIDTH = 56,
  parameter int FRAME_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [DATA_WIDTH-1:0] out5,
  output logic [DATA_WIDTH-1:0] out6,
  output logic [DATA_WIDTH-1:0] out7,
  output logic                  data_valid,
  output logic                  bank,
  output logic                  frame_done,
  output logic                  sop_err
);

  localparam int GRP_W = $clog2(FRAME_LEN / 8);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(FRAME_LEN / 8 - 1);

  typedef enum logic {WAIT_SOP, RUN} state_t;

  state_t                  state;
  logic [2:0]              lane_cnt;
  logic [GRP_W-1:0]        grp_cnt;
  logic [DATA_WIDTH-1:0]   hold [0:7];
  logic                    accept;
  logic                    first_idx;
  logic                    sop_bad;

  assign accept    = in_valid && (state == RUN || in_sop);
  assign first_idx = (lane_cnt == 3'd0) && (grp_cnt == '0);
  // Misplaced SOPs are only flagged; alignment is kept so the downstream
  // free-running write pointer stays in step with the sample index.
  assign sop_bad   = (state == RUN) && (first_idx != in_sop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_SOP;
      lane_cnt   <= '0;
      grp_cnt    <= '0;
      for (int k = 0; k < 8; k++) hold[k] <= '0;
      out0       <= '0;
      out1       <= '0;
      out2       <= '0;
      out3       <= '0;
      out4       <= '0;
      out5       <= '0;
      out6       <= '0;
      out7       <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      sop_err    <= 1'b0;
      bank       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      sop_err    <= accept && sop_bad;
      if (frame_done) bank <= ~bank;
      if (accept) begin
        state          <= RUN;
        hold[lane_cnt] <= in_data;
        lane_cnt       <= lane_cnt + 3'd1;
        if (lane_cnt == 3'd7) begin
          out0       <= hold[0];
          out1       <= hold[1];
          out2       <= hold[2];
          out3       <= hold[3];
          out4       <= hold[4];
          out5       <= hold[5];
          out6       <= hold[6];
          out7       <= in_data;
          data_valid <= 1'b1;
          frame_done <= (grp_cnt == GRP_LAST);
          grp_cnt    <= grp_cnt + GRP_W'(1);
        end
      end
    end
  end

endmodule
